// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch stage: FU class encoding, the class decoder
// and the buffered instruction entry. Entry field widths follow the DP_*
// constants below; the dispatch_router parameters default to these values.
package dispatch_pkg;

  localparam int DP_INST_ID_BITS = 6;
  localparam int DP_PRN_BITS     = 6;
  localparam int DP_MAX_OPERANDS = 3;

  typedef enum logic [1:0] {
    FU_ALU     = 2'd0,
    FU_LOGICAL = 2'd1,
    FU_LDST    = 2'd2,
    FU_BRANCH  = 2'd3
  } fu_class_e;

  // Coarse AArch64 decode, checked top-down so that earlier classes win.
  function automatic fu_class_e fu_class(input logic [31:0] instr);
    fu_class_e c;
    c = FU_ALU;
    if (instr[28:26] == 3'b101) begin
      c = FU_BRANCH;
    end else if (instr[27] && !instr[25]) begin
      c = FU_LDST;
    end else if ((instr[28:24] == 5'b01010) || (instr[28:23] == 6'b100100)) begin
      c = FU_LOGICAL;
    end
    return c;
  endfunction

  typedef struct packed {
    logic [DP_INST_ID_BITS-1:0]                     id;
    logic [31:0]                                    instr;
    logic [63:0]                                    pc;
    logic [DP_MAX_OPERANDS-1:0]                     in_valid;
    logic [DP_MAX_OPERANDS-1:0][DP_PRN_BITS-1:0]    in_prn;
    logic [DP_MAX_OPERANDS-1:0]                     out_valid;
    logic [DP_MAX_OPERANDS-1:0][DP_PRN_BITS-1:0]    out_prn;
    fu_class_e                                      cls;
  } dispatch_entry_t;

endpackage

// File: rtl/prn_scoreboard.sv
// PRN busy scoreboard. A bit is set when a producer dispatches and cleared
// by any writeback wake-up; a set and a clear of the same PRN in one cycle
// leaves it busy. Lookups see same-cycle wake-ups (forwarding).
module prn_scoreboard #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [MAX_OPERANDS-1:0]                        set_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          set_prn,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]          clr_valid,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] clr_prn,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          lookup_prn,
  output logic [MAX_OPERANDS-1:0]                        lookup_ready
);

  localparam int NUM_PRN = 1 << PRN_BITS;

  logic [NUM_PRN-1:0] busy;
  logic [NUM_PRN-1:0] busy_next;
  logic [NUM_PRN-1:0] set_mask;
  logic [NUM_PRN-1:0] clr_mask;

  // Decode set/clear requests into masks; set is applied after clear so it wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (set_valid[i]) set_mask[set_prn[i]] = 1'b1;
    end
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        if (clr_valid[f][i]) clr_mask[clr_prn[f][i]] = 1'b1;
      end
    end
    busy_next = (busy & ~clr_mask) | set_mask;
  end

  // Busy vector register; reset marks every PRN ready.
  always_ff @(posedge clk) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  // Operand is ready when not busy or being woken this very cycle.
  always_comb begin
    lookup_ready = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      lookup_ready[i] = !busy[lookup_prn[i]] || clr_mask[lookup_prn[i]];
    end
  end

endmodule

// File: rtl/dispatch_router.sv
// In-order dispatch stage: small FIFO of renamed instructions, FU class
// decode and PRN scoreboard. The head entry is offered to exactly one FU
// issue queue and held stable until that queue accepts it.
// Optional feature macro: DISPATCH_BYPASS_EN (empty-FIFO same-cycle dispatch).
//
// Handshakes: in_valid/in_ready transfer on the clock edge where both are
// high (in_ready depends only on registered occupancy); fu_inst_valid[k] /
// fu_queue_ready[k] transfer when both are high, and fu_inst_valid plus all
// head fields stay stable until that happens (flush excepted).
module dispatch_router
  import dispatch_pkg::*;
#(
  parameter int INST_ID_BITS = DP_INST_ID_BITS,
  parameter int PRN_BITS     = DP_PRN_BITS,
  parameter int MAX_OPERANDS = DP_MAX_OPERANDS,
  parameter int FU_COUNT     = 4,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [INST_ID_BITS-1:0]                        in_inst_id,
  input  logic [31:0]                                    in_raw_instr,
  input  logic [63:0]                                    in_pc,
  input  logic [MAX_OPERANDS-1:0]                        in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                        in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          in_prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]          set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  output logic [FU_COUNT-1:0]                            fu_inst_valid,
  input  logic [FU_COUNT-1:0]                            fu_queue_ready,
  output logic [INST_ID_BITS-1:0]                        inst_id,
  output logic [31:0]                                    raw_instr,
  output logic [63:0]                                    instr_pc,
  output logic [MAX_OPERANDS-1:0]                        prn_input_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          prn_input,
  output logic [MAX_OPERANDS-1:0]                        prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          prn_output,
  output logic [MAX_OPERANDS-1:0]                        prn_input_ready
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dispatch_entry_t mem [BUF_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  dispatch_entry_t in_entry;
  dispatch_entry_t sel;
  logic            sel_valid;
  logic            empty;
  logic            full;
  logic            bypass;
  logic            dispatch;
  logic            push;
  logic            pop;
  logic [MAX_OPERANDS-1:0] sb_set_valid;
  logic [MAX_OPERANDS-1:0] sb_lookup_ready;

  // Classes without a matching issue queue fall back to the ALU queue.
  function automatic fu_class_e clamp_class(input fu_class_e c);
    return (int'(c) < FU_COUNT) ? c : FU_ALU;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(BUF_DEPTH));

  // Pack the incoming instruction and decode its target queue.
  always_comb begin
    in_entry           = '0;
    in_entry.id        = in_inst_id;
    in_entry.instr     = in_raw_instr;
    in_entry.pc        = in_pc;
    in_entry.in_valid  = in_prn_input_valid;
    in_entry.in_prn    = in_prn_input;
    in_entry.out_valid = in_prn_output_valid;
    in_entry.out_prn   = in_prn_output;
    in_entry.cls       = clamp_class(fu_class(in_raw_instr));
  end

`ifdef DISPATCH_BYPASS_EN
  assign bypass = rst && !flush && empty && in_valid && fu_queue_ready[in_entry.cls];
`else
  assign bypass = 1'b0;
`endif

  // Choose the entry presented to the FU queues: FIFO head, else bypassed input.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    if (rst) begin
      if (!empty) begin
        sel       = mem[head_ptr];
        sel_valid = !flush;
      end else if (bypass) begin
        sel       = in_entry;
        sel_valid = 1'b1;
      end
    end
  end

  // One-hot strobe towards the selected entry's FU queue.
  always_comb begin
    fu_inst_valid = '0;
    for (int c = 0; c < FU_COUNT; c++) begin
      fu_inst_valid[c] = sel_valid && (int'(sel.cls) == c);
    end
  end

  assign dispatch = |(fu_inst_valid & fu_queue_ready);
  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready && !flush && !bypass;
  assign pop      = dispatch && !empty;

  assign inst_id          = sel.id;
  assign raw_instr        = sel.instr;
  assign instr_pc         = sel.pc;
  assign prn_input_valid  = sel.in_valid;
  assign prn_input        = sel.in_prn;
  assign prn_output_valid = sel.out_valid;
  assign prn_output       = sel.out_prn;

  // FIFO pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= in_entry;
  end

  assign sb_set_valid = dispatch ? sel.out_valid : '0;

  prn_scoreboard #(
    .PRN_BITS     (PRN_BITS),
    .MAX_OPERANDS (MAX_OPERANDS),
    .FU_COUNT     (FU_COUNT)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_valid    (sb_set_valid),
    .set_prn      (sel.out_prn),
    .clr_valid    (set_prn_ready),
    .clr_prn      (set_prn),
    .lookup_prn   (sel.in_prn),
    .lookup_ready (sb_lookup_ready)
  );

  // Unused source slots always read as ready; everything reads 0 in reset.
  always_comb begin
    prn_input_ready = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      prn_input_ready[i] = rst && (!sel.in_valid[i] || sb_lookup_ready[i]);
    end
  end

endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: directed scenarios plus a randomized run, all
// checked against a queue/array reference model of the dispatch rules.
module tb_dispatch_router;

  localparam int IB = 6;
  localparam int PB = 6;
  localparam int MO = 3;
  localparam int FC = 4;
`ifdef DISPATCH_BYPASS_EN
  localparam int LAT = 0;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] I_AND = 32'h8A020020;
  localparam logic [31:0] I_LDR = 32'hF9400020;
  localparam logic [31:0] I_ADD = 32'h8B020020;
  localparam logic [31:0] I_B   = 32'h14000010;
  localparam logic [31:0] I_LOG = 32'h12000000;

  typedef struct packed {
    logic [IB-1:0]          id;
    logic [31:0]            instr;
    logic [63:0]            pc;
    logic [MO-1:0]          iv;
    logic [MO-1:0][PB-1:0]  ip;
    logic [MO-1:0]          ov;
    logic [MO-1:0][PB-1:0]  op;
  } ent_t;
  localparam int EW = $bits(ent_t);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  ent_t drv = '0;
  logic [FC-1:0][MO-1:0] set_prn_ready = '0;
  logic [FC-1:0][MO-1:0][PB-1:0] set_prn = '0;
  logic [FC-1:0] fu_queue_ready = '0;

  logic in_ready;
  logic [FC-1:0] fu_inst_valid;
  logic [IB-1:0] inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic [MO-1:0] prn_input_valid, prn_output_valid, prn_input_ready;
  logic [MO-1:0][PB-1:0] prn_input, prn_output;

  logic [EW-1:0] exp_q[$];
  bit busy_m [64];
  int checks = 0;
  int errors = 0;

  logic [FC-1:0] e_fu;
  logic e_ready;
  logic [MO-1:0] e_pir;
  ent_t e_ent;
  bit e_byp;

  // Clock generation.
  always #5 clk = ~clk;

  dispatch_router dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_inst_id          (drv.id),
    .in_raw_instr        (drv.instr),
    .in_pc               (drv.pc),
    .in_prn_input_valid  (drv.iv),
    .in_prn_input        (drv.ip),
    .in_prn_output_valid (drv.ov),
    .in_prn_output       (drv.op),
    .set_prn_ready       (set_prn_ready),
    .set_prn             (set_prn),
    .fu_inst_valid       (fu_inst_valid),
    .fu_queue_ready      (fu_queue_ready),
    .inst_id             (inst_id),
    .raw_instr           (raw_instr),
    .instr_pc            (instr_pc),
    .prn_input_valid     (prn_input_valid),
    .prn_input           (prn_input),
    .prn_output_valid    (prn_output_valid),
    .prn_output          (prn_output),
    .prn_input_ready     (prn_input_ready)
  );

  // FU class from encoding masks, earlier rules first.
  function automatic int cls_of(logic [31:0] x);
    if ((x & 32'h1C00_0000) == 32'h1400_0000) return 3;
    if ((x & 32'h0A00_0000) == 32'h0800_0000) return 2;
    if (((x & 32'h1F00_0000) == 32'h0A00_0000) || ((x & 32'h1F80_0000) == 32'h1200_0000)) return 1;
    return 0;
  endfunction

  function automatic bit woken(logic [PB-1:0] p);
    for (int f = 0; f < FC; f++)
      for (int i = 0; i < MO; i++)
        if (set_prn_ready[f][i] && set_prn[f][i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t mk(logic [IB-1:0] id, logic [31:0] instr, logic [MO-1:0] iv,
                              logic [PB-1:0] ip0, logic [MO-1:0] ov, logic [PB-1:0] op0);
    ent_t e;
    e = '0;
    e.id = id;
    e.instr = instr;
    e.pc = 64'h4000 + 64'(id) * 4;
    e.iv = iv;
    e.ip[0] = ip0;
    e.ov = ov;
    e.op[0] = op0;
    return e;
  endfunction

  // Expected outputs for the current inputs and model state.
  task automatic model_expect();
    bit present;
    present = 1'b0;
    e_fu = '0; e_ready = 1'b0; e_pir = '0; e_ent = '0; e_byp = 1'b0;
    if (rst) begin
      e_ready = (exp_q.size() < 4);
      if (exp_q.size() > 0) begin
        e_ent = ent_t'(exp_q[0]);
        present = 1'b1;
      end else if (BYP && in_valid && !flush && fu_queue_ready[cls_of(drv.instr)]) begin
        e_ent = drv;
        present = 1'b1;
        e_byp = 1'b1;
      end
      if (present && !flush) e_fu = FC'(1) << cls_of(e_ent.instr);
      for (int i = 0; i < MO; i++)
        e_pir[i] = !e_ent.iv[i] || !busy_m[e_ent.ip[i]] || woken(e_ent.ip[i]);
    end
  endtask

  // Advance the model across one clock edge using the pre-edge expectations.
  task automatic model_update();
    bit disp, push;
    if (!rst) begin
      exp_q.delete();
      for (int p = 0; p < 64; p++) busy_m[p] = 1'b0;
    end else begin
      disp = ((e_fu & fu_queue_ready) != '0);
      push = in_valid && e_ready && !flush && !e_byp;
      for (int f = 0; f < FC; f++)
        for (int i = 0; i < MO; i++)
          if (set_prn_ready[f][i]) busy_m[set_prn[f][i]] = 1'b0;
      if (disp)
        for (int i = 0; i < MO; i++)
          if (e_ent.ov[i]) busy_m[e_ent.op[i]] = 1'b1;
      if (flush) exp_q.delete();
      else begin
        if (disp && !e_byp) void'(exp_q.pop_front());
        if (push) exp_q.push_back(EW'(drv));
      end
    end
  endtask

  task automatic clk_step();
    model_expect();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Returns cycles until a strobe appears (-1 if none); drops in_valid after the first edge.
  task automatic wait_strobe(output int cyc);
    cyc = -1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (fu_inst_valid != '0) begin
        cyc = k;
        break;
      end
      clk_step();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; drv = mk(6'd5, I_AND, 3'b001, 6'd1, 3'b001, 6'd2);
    fu_queue_ready = '1;
    clk_step(); clk_step();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (fu_inst_valid !== 4'b0000) begin errors++; $display("FAIL reset_fu_valid got %b exp 0000", fu_inst_valid); end
    checks++; if (inst_id !== '0 || raw_instr !== '0 || prn_input_ready !== '0) begin errors++;
      $display("FAIL reset_data got id %h instr %h pir %b exp zeros", inst_id, raw_instr, prn_input_ready); end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    checks++; if (prn_input_ready !== 3'b111) begin errors++; $display("FAIL post_reset_pir got %b exp 111", prn_input_ready); end
    clk_step();
  endtask

  task automatic test_decode();
    int cyc;
    fu_queue_ready = 4'b0010;
    drv = mk(6'd1, I_AND, 3'b000, 6'd0, 3'b000, 6'd0); in_valid = 1'b1;
    wait_strobe(cyc);
    checks++; if (cyc != LAT) begin errors++; $display("FAIL and_latency got %0d exp %0d", cyc, LAT); end
    checks++; if (fu_inst_valid !== 4'b0010) begin errors++; $display("FAIL and_fu got %b exp 0010", fu_inst_valid); end
    checks++; if (raw_instr !== I_AND || inst_id !== 6'd1 || instr_pc !== 64'h4004) begin errors++;
      $display("FAIL and_fields got %h %h %h exp %h 01 4004", raw_instr, inst_id, instr_pc, I_AND); end
    clk_step(); in_valid = 1'b0;
    #1;
    checks++; if (fu_inst_valid !== 4'b0000) begin errors++; $display("FAIL and_drained got %b exp 0000", fu_inst_valid); end
    fu_queue_ready = 4'b0100;
    drv = mk(6'd2, I_LDR, 3'b000, 6'd0, 3'b000, 6'd0); in_valid = 1'b1;
    wait_strobe(cyc);
    checks++; if (cyc != LAT) begin errors++; $display("FAIL ldr_latency got %0d exp %0d", cyc, LAT); end
    checks++; if (fu_inst_valid !== 4'b0100 || raw_instr !== I_LDR) begin errors++;
      $display("FAIL ldr_fu got %b %h exp 0100 %h", fu_inst_valid, raw_instr, I_LDR); end
    clk_step(); in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5];
    int got[$];
    bit acc;
    ins[0] = I_LDR; ins[1] = I_AND; ins[2] = I_ADD; ins[3] = I_B; ins[4] = I_LDR;
    fu_queue_ready = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      drv = mk(IB'(10 + k), ins[k], 3'b000, 6'd0, 3'b000, 6'd0); in_valid = 1'b1;
      clk_step();
    end
    drv = mk(6'd14, ins[4], 3'b000, 6'd0, 3'b000, 6'd0); in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    checks++; if (fu_inst_valid !== 4'b0100 || inst_id !== 6'd10) begin errors++;
      $display("FAIL hol_hold got %b id %0d exp 0100 id 10", fu_inst_valid, inst_id); end
    fu_queue_ready = 4'b1111;
    for (int k = 0; k < 12 && got.size() < 5; k++) begin
      #1;
      acc = in_valid && in_ready;
      if ((fu_inst_valid & fu_queue_ready) != '0) got.push_back(int'(inst_id));
      clk_step();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (got.size() != 5) begin errors++; $display("FAIL drain_count got %0d exp 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got.size() <= i || got[i] != 10 + i) begin errors++;
        $display("FAIL drain_order idx %0d got %0d exp %0d", i, (got.size() > i) ? got[i] : -1, 10 + i); end
    end
  endtask

  task automatic test_scoreboard();
    int cyc;
    fu_queue_ready = 4'b1111;
    drv = mk(6'd20, I_ADD, 3'b000, 6'd0, 3'b001, 6'd9); in_valid = 1'b1;
    wait_strobe(cyc);
    checks++; if (fu_inst_valid !== 4'b0001) begin errors++; $display("FAIL prod_fu got %b exp 0001", fu_inst_valid); end
    clk_step(); in_valid = 1'b0;
    fu_queue_ready = 4'b1110;
    drv = mk(6'd21, I_ADD, 3'b001, 6'd9, 3'b000, 6'd0); in_valid = 1'b1;
    wait_strobe(cyc);
    checks++; if (prn_input_ready[0] !== 1'b0) begin errors++; $display("FAIL src_busy got %b exp 0", prn_input_ready[0]); end
    set_prn_ready[1][0] = 1'b1; set_prn[1][0] = 6'd9;
    #1;
    checks++; if (prn_input_ready[0] !== 1'b1) begin errors++; $display("FAIL wake_forward got %b exp 1", prn_input_ready[0]); end
    clk_step(); in_valid = 1'b0; set_prn_ready = '0;
    #1;
    checks++; if (prn_input_ready[0] !== 1'b1) begin errors++; $display("FAIL wake_cleared got %b exp 1", prn_input_ready[0]); end
    fu_queue_ready = 4'b1111;
    clk_step();
  endtask

  task automatic test_set_wins();
    int cyc;
    fu_queue_ready = 4'b1111;
    drv = mk(6'd30, I_ADD, 3'b000, 6'd0, 3'b001, 6'd12); in_valid = 1'b1;
    wait_strobe(cyc);
    set_prn_ready[2][1] = 1'b1; set_prn[2][1] = 6'd12;
    clk_step(); in_valid = 1'b0; set_prn_ready = '0;
    fu_queue_ready = 4'b1110;
    drv = mk(6'd31, I_ADD, 3'b001, 6'd12, 3'b000, 6'd0); in_valid = 1'b1;
    wait_strobe(cyc);
    checks++; if (prn_input_ready[0] !== 1'b0) begin errors++; $display("FAIL set_wins got %b exp 0", prn_input_ready[0]); end
    clk_step(); in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      drv = mk(IB'(40 + k), I_ADD, 3'b000, 6'd0, 3'b000, 6'd0); in_valid = 1'b1;
      clk_step();
    end
    fu_queue_ready = 4'b1111; flush = 1'b1;
    drv = mk(6'd42, I_AND, 3'b000, 6'd0, 3'b000, 6'd0); in_valid = 1'b1;
    #1;
    checks++; if (fu_inst_valid !== 4'b0000) begin errors++; $display("FAIL flush_no_dispatch got %b exp 0000", fu_inst_valid); end
    clk_step(); flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (fu_inst_valid !== 4'b0000 || in_ready !== 1'b1) begin errors++;
      $display("FAIL flush_empty got fu %b rdy %b exp 0000 1", fu_inst_valid, in_ready); end
    drv = mk(6'd43, I_ADD, 3'b001, 6'd12, 3'b000, 6'd0); in_valid = 1'b1;
    wait_strobe(cyc);
    checks++; if (cyc != LAT) begin errors++; $display("FAIL post_flush_latency got %0d exp %0d", cyc, LAT); end
    checks++; if (fu_inst_valid !== 4'b0001 || inst_id !== 6'd43) begin errors++;
      $display("FAIL post_flush_head got %b id %0d exp 0001 id 43", fu_inst_valid, inst_id); end
    checks++; if (prn_input_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_keeps_sb got %b exp 0", prn_input_ready[0]); end
    clk_step(); in_valid = 1'b0;
    set_prn_ready[0][0] = 1'b1; set_prn[0][0] = 6'd12;
    clk_step(); set_prn_ready = '0;
  endtask

  task automatic test_random();
    logic [31:0] tbl [6];
    int sel;
    tbl[0] = I_AND; tbl[1] = I_LDR; tbl[2] = I_ADD; tbl[3] = I_B; tbl[4] = I_LOG; tbl[5] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 6);
      drv = '0;
      drv.id = IB'($urandom);
      drv.instr = (sel == 6) ? 32'($urandom) : tbl[sel];
      drv.pc = {32'($urandom), 32'($urandom)};
      drv.iv = MO'($urandom);
      drv.ov = MO'($urandom);
      for (int i = 0; i < MO; i++) begin
        drv.ip[i] = PB'($urandom_range(0, 7));
        drv.op[i] = PB'($urandom_range(0, 7));
      end
      in_valid = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      for (int f = 0; f < FC; f++) begin
        fu_queue_ready[f] = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < MO; i++) begin
          set_prn_ready[f][i] = ($urandom_range(0, 7) == 0);
          set_prn[f][i] = PB'($urandom_range(0, 7));
        end
      end
      #1;
      model_expect();
      checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", n, in_ready, e_ready); end
      checks++; if (fu_inst_valid !== e_fu) begin errors++; $display("FAIL rand_fu cyc %0d got %b exp %b", n, fu_inst_valid, e_fu); end
      if (e_fu != '0) begin
        checks++;
        if ({inst_id, raw_instr, instr_pc, prn_input_valid, prn_input, prn_output_valid, prn_output} !== EW'(e_ent)) begin
          errors++; $display("FAIL rand_fields cyc %0d got id %h instr %h exp id %h instr %h", n, inst_id, raw_instr, e_ent.id, e_ent.instr);
        end
        checks++; if (prn_input_ready !== e_pir) begin errors++; $display("FAIL rand_pir cyc %0d got %b exp %b", n, prn_input_ready, e_pir); end
      end
      clk_step();
    end
    flush = 1'b0; in_valid = 1'b0; set_prn_ready = '0; fu_queue_ready = '1;
    for (int k = 0; k < 6; k++) clk_step();
  endtask

  // Watchdog bounding the whole run.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_scoreboard();
    test_set_wins();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
